// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcodes,
// ALUOp codes, datapath mux selects and the decoder's instruction classes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_RWB    = 4'd4,
        S_MEMADR = 4'd5,
        S_MEMRD  = 4'd6,
        S_MEMWB  = 4'd7,
        S_MEMWR  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_JAL    = 4'd11,
        S_IMMEX  = 4'd12,
        S_IMMWB  = 4'd13,
        S_TRAP   = 4'd14
    } state_t;

    typedef enum logic [2:0] {
        CL_R, CL_MEM, CL_BRANCH, CL_JUMP, CL_JAL, CL_IMM, CL_ILLEGAL
    } op_class_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_XOR   = 3'b110;
    localparam logic [2:0] ALU_LUI   = 3'b111;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_31 = 2'b10;

endpackage

// File: rtl/multicycle_op_decode.sv
// Combinational opcode decoder: instruction class, immediate extension mode
// and ALUOp for the immediate-execute state.
// Build option: CTRL_EXT_OP_EN adds xori/lui to the immediate table.
module multicycle_op_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic [OP_W-1:0]    op,
    output op_class_t          op_class,
    output logic               ext_mode,
    output logic [ALUOP_W-1:0] imm_aluop,
    output logic               legal
);

    // opcode lookup; anything not listed is illegal
    always_comb begin
        op_class  = CL_ILLEGAL;
        ext_mode  = 1'b0;
        imm_aluop = ALUOP_W'(ALU_ADD);
        case (op)
            OP_W'(OP_R):    op_class = CL_R;
            OP_W'(OP_LW),
            OP_W'(OP_SW):   op_class = CL_MEM;
            OP_W'(OP_BEQ),
            OP_W'(OP_BNE):  op_class = CL_BRANCH;
            OP_W'(OP_J):    op_class = CL_JUMP;
            OP_W'(OP_JAL):  op_class = CL_JAL;
            OP_W'(OP_ADDI): begin
                op_class  = CL_IMM;
                ext_mode  = 1'b1;
                imm_aluop = ALUOP_W'(ALU_ADD);
            end
            OP_W'(OP_SLTI): begin
                op_class  = CL_IMM;
                ext_mode  = 1'b1;
                imm_aluop = ALUOP_W'(ALU_SLT);
            end
            OP_W'(OP_ANDI): begin
                op_class  = CL_IMM;
                imm_aluop = ALUOP_W'(ALU_AND);
            end
            OP_W'(OP_ORI): begin
                op_class  = CL_IMM;
                imm_aluop = ALUOP_W'(ALU_OR);
            end
`ifdef CTRL_EXT_OP_EN
            OP_W'(OP_XORI): begin
                op_class  = CL_IMM;
                imm_aluop = ALUOP_W'(ALU_XOR);
            end
            OP_W'(OP_LUI): begin
                op_class  = CL_IMM;
                imm_aluop = ALUOP_W'(ALU_LUI);
            end
`endif
            default: op_class = CL_ILLEGAL;
        endcase
    end

    assign legal = (op_class != CL_ILLEGAL);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: Moore FSM with memory-wait timeout trap.
// Build option: CTRL_EXT_OP_EN (forwarded to multicycle_op_decode).
//
// state    | meaning
// S_RESET  | held in reset, all strobes off
// S_FETCH  | read instruction at PC, PC+4 on mem_ready
// S_DECODE | compute branch target, dispatch on op
// S_EXEC   | R-type ALU operation
// S_RWB    | R-type write-back to rd
// S_MEMADR | load/store address computation
// S_MEMRD  | data read, waits on mem_ready
// S_MEMWB  | load write-back from MDR to rt
// S_MEMWR  | data write, waits on mem_ready
// S_BRANCH | beq/bne compare and conditional PC load
// S_JUMP   | j: PC <- jump target
// S_JAL    | jal: PC <- jump target, $31 <- PC
// S_IMMEX  | immediate ALU operation
// S_IMMWB  | immediate write-back to rt
// S_TRAP   | illegal opcode or memory timeout, absorbing
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               BranchNe,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         RegDst,
    output logic               MemtoReg,
    output logic               PCToReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               ExtMode,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSource,
    output logic               illegal,
    output logic [3:0]         state_o
);

    state_t             state, state_next;
    logic [TO_W-1:0]    wait_cnt;
    logic               mem_state;
    logic               timeout_hit;
    op_class_t          dec_class;
    logic               dec_ext;
    logic [ALUOP_W-1:0] dec_aluop;
    logic               dec_legal;

    multicycle_op_decode #(
        .OP_W    (OP_W),
        .ALUOP_W (ALUOP_W)
    ) u_decode (
        .op        (op),
        .op_class  (dec_class),
        .ext_mode  (dec_ext),
        .imm_aluop (dec_aluop),
        .legal     (dec_legal)
    );

    assign mem_state   = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    // the last allowed not-ready cycle: its closing edge would make the count reach MEM_TIMEOUT
    assign timeout_hit = mem_state && !mem_ready && (wait_cnt == TO_W'(MEM_TIMEOUT - 1));

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_RESET;
        else       state <= state_next;
    end

    // wait counter: clears on every state change, counts not-ready cycles in memory states
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        wait_cnt <= '0;
        else if (state_next != state)     wait_cnt <= '0;
        else if (mem_state && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_RESET:  state_next = S_FETCH;
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
                      else if (timeout_hit) state_next = S_TRAP;
            S_DECODE: begin
                if (!dec_legal) state_next = S_TRAP;
                else begin
                    case (dec_class)
                        CL_R:      state_next = S_EXEC;
                        CL_MEM:    state_next = S_MEMADR;
                        CL_BRANCH: state_next = S_BRANCH;
                        CL_JUMP:   state_next = S_JUMP;
                        CL_JAL:    state_next = S_JAL;
                        CL_IMM:    state_next = S_IMMEX;
                        default:   state_next = S_TRAP;
                    endcase
                end
            end
            S_EXEC:   state_next = S_RWB;
            S_MEMADR: state_next = (op == OP_W'(OP_SW)) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
                      else if (timeout_hit) state_next = S_TRAP;
            S_MEMWR:  if (mem_ready) state_next = S_FETCH;
                      else if (timeout_hit) state_next = S_TRAP;
            S_IMMEX:  state_next = S_IMMWB;
            S_RWB, S_MEMWB, S_BRANCH, S_JUMP, S_JAL, S_IMMWB:
                      state_next = S_FETCH;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_TRAP;
        endcase
    end

    // Moore output table; only FETCH's IRWrite/PCWrite look at mem_ready
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = RD_RT;
        MemtoReg    = 1'b0;
        PCToReg     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ExtMode     = 1'b0;
        ALUOp       = ALUOP_W'(ALU_ADD);
        PCSource    = PCSRC_ALU;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_4;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM2;
                ExtMode = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_W'(ALU_FUNCT);
            end
            S_RWB: begin
                RegDst   = RD_RD;
                RegWrite = 1'b1;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ExtMode = 1'b1;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_W'(ALU_SUB);
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_OUT;
                BranchNe    = op[0];
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            S_JAL: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
                RegDst   = RD_31;
                PCToReg  = 1'b1;
                RegWrite = 1'b1;
            end
            S_IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ExtMode = dec_ext;
                ALUOp   = dec_aluop;
            end
            S_IMMWB: begin
                RegWrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal = (state == S_TRAP);
    assign state_o = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control. The driver walks each
// instruction through the state sequence implied by the dispatch and latency
// rules, pushing the expected output vector for every cycle; a negedge
// monitor pops and compares against the DUT.
module tb_multicycle_control;
    import ctrl_pkg::*;

`ifdef CTRL_EXT_OP_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif
    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcwc, bne, iord, mrd, mwr, irw;
        logic [1:0] regdst;
        logic       m2r, pc2r, rw, srca;
        logic [1:0] srcb;
        logic       ext;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
        logic       ill;
    } ovec_t;

    typedef enum int { K_R, K_LW, K_SW, K_BR, K_J, K_JAL, K_IMM, K_ILL } kind_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mem_ready = 1'b0;
    logic [5:0] op = 6'h00;
    logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0] RegDst;
    logic       MemtoReg, PCToReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ExtMode;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic       illegal;
    logic [3:0] state_o;

    ovec_t      act, mon_e;
    ovec_t      exp_q[$];
    logic [5:0] cur_op = 6'h00;
    int         n_vec = 0;
    int         n_bad = 0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .PCToReg(PCToReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtMode(ExtMode), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal(illegal), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign act = {state_o, PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
                  RegDst, MemtoReg, PCToReg, RegWrite, ALUSrcA, ALUSrcB, ExtMode, ALUOp,
                  PCSource, illegal};

    function automatic kind_t kind_of(input logic [5:0] o);
        case (o)
            6'h00:               return K_R;
            6'h23:               return K_LW;
            6'h2B:               return K_SW;
            6'h04, 6'h05:        return K_BR;
            6'h02:               return K_J;
            6'h03:               return K_JAL;
            6'h08, 6'h0A,
            6'h0C, 6'h0D:        return K_IMM;
            6'h0E, 6'h0F:        return EXT_EN ? K_IMM : K_ILL;
            default:             return K_ILL;
        endcase
    endfunction

    function automatic ovec_t expect_of(input state_t s, input logic mr, input logic [5:0] o);
        ovec_t e;
        e = '0;
        e.st = s;
        case (s)
            S_FETCH:  begin e.mrd = 1; e.srcb = 2'b01; e.irw = mr; e.pcw = mr; end
            S_DECODE: begin e.srcb = 2'b11; e.ext = 1; end
            S_EXEC:   begin e.srca = 1; e.aluop = 3'b010; end
            S_RWB:    begin e.regdst = 2'b01; e.rw = 1; end
            S_MEMADR: begin e.srca = 1; e.srcb = 2'b10; e.ext = 1; end
            S_MEMRD:  begin e.mrd = 1; e.iord = 1; end
            S_MEMWB:  begin e.m2r = 1; e.rw = 1; end
            S_MEMWR:  begin e.mwr = 1; e.iord = 1; end
            S_BRANCH: begin e.srca = 1; e.aluop = 3'b001; e.pcwc = 1; e.pcsrc = 2'b01; e.bne = o[0]; end
            S_JUMP:   begin e.pcw = 1; e.pcsrc = 2'b10; end
            S_JAL:    begin e.pcw = 1; e.pcsrc = 2'b10; e.regdst = 2'b10; e.pc2r = 1; e.rw = 1; end
            S_IMMEX: begin
                e.srca = 1;
                e.srcb = 2'b10;
                case (o)
                    6'h08:   begin e.ext = 1; e.aluop = 3'b000; end
                    6'h0A:   begin e.ext = 1; e.aluop = 3'b101; end
                    6'h0C:   e.aluop = 3'b011;
                    6'h0D:   e.aluop = 3'b100;
                    6'h0E:   e.aluop = 3'b110;
                    6'h0F:   e.aluop = 3'b111;
                    default: e.aluop = 3'b000;
                endcase
            end
            S_IMMWB:  e.rw = 1;
            S_TRAP:   e.ill = 1;
            default:  ;
        endcase
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // scoreboard monitor: one compare per expected cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_vec++;
            if (act !== mon_e) begin
                n_bad++;
                $display("FAIL cycle_out t=%0t state got %0d want %0d, vector got %h want %h",
                         $time, act.st, mon_e.st, act, mon_e);
            end
        end
    end

    task automatic cyc(input state_t s, input logic mr, input logic rst);
        @(posedge clk);
        #1;
        reset     = rst;
        mem_ready = mr;
        op        = cur_op;
        exp_q.push_back(expect_of(s, mr, cur_op));
    endtask

    task automatic do_reset(input int hold);
        for (int i = 0; i < hold; i++) cyc(S_RESET, rb(), 1'b1);
        cyc(S_RESET, rb(), 1'b0);
    endtask

    task automatic mem_wait(input state_t s, input int w, output bit tr);
        tr = 1'b0;
        for (int i = 0; i < w && i < TIMEOUT; i++) cyc(s, 1'b0, 1'b0);
        if (w >= TIMEOUT) tr = 1'b1;
        else              cyc(s, 1'b1, 1'b0);
    endtask

    task automatic run_instr(input logic [5:0] o, input int fw, input int dw);
        bit tr;
        cur_op = o;
        mem_wait(S_FETCH, fw, tr);
        if (!tr) begin
            cyc(S_DECODE, rb(), 1'b0);
            case (kind_of(o))
                K_R:   begin cyc(S_EXEC, rb(), 1'b0); cyc(S_RWB, rb(), 1'b0); end
                K_LW:  begin
                    cyc(S_MEMADR, rb(), 1'b0);
                    mem_wait(S_MEMRD, dw, tr);
                    if (!tr) cyc(S_MEMWB, rb(), 1'b0);
                end
                K_SW:  begin cyc(S_MEMADR, rb(), 1'b0); mem_wait(S_MEMWR, dw, tr); end
                K_BR:  cyc(S_BRANCH, rb(), 1'b0);
                K_J:   cyc(S_JUMP, rb(), 1'b0);
                K_JAL: cyc(S_JAL, rb(), 1'b0);
                K_IMM: begin cyc(S_IMMEX, rb(), 1'b0); cyc(S_IMMWB, rb(), 1'b0); end
                default: tr = 1'b1;
            endcase
        end
        if (tr) begin
            repeat (3) cyc(S_TRAP, rb(), 1'b0);
            do_reset(2);
        end
    endtask

    function automatic int rand_wait();
        if ($urandom_range(0, 24) == 0) return TIMEOUT + int'($urandom_range(0, 2));
        if ($urandom_range(0, 9) == 0)  return TIMEOUT - 1;
        return int'($urandom_range(0, 3));
    endfunction

    logic [5:0] op_pool [16] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08,
                                 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h01, 6'h3F, 6'h00};

    initial begin
        // reset held three cycles, then release with memory ready
        for (int i = 0; i < 3; i++) cyc(S_RESET, 1'b1, 1'b1);
        cyc(S_RESET, 1'b1, 1'b0);

        run_instr(6'h00, 0, 0);
        run_instr(6'h23, 0, 3);
        run_instr(6'h2B, 0, 40);
        run_instr(6'h05, 0, 0);
        run_instr(6'h04, 1, 0);
        run_instr(6'h03, 0, 0);
        run_instr(6'h02, 2, 0);
        run_instr(6'h0F, 0, 0);
        run_instr(6'h0E, 0, 0);
        run_instr(6'h23, TIMEOUT - 1, TIMEOUT - 1);
        run_instr(6'h23, 0, TIMEOUT);
        run_instr(6'h00, TIMEOUT, 0);

        for (int n = 0; n < 400; n++)
            run_instr(op_pool[$urandom_range(0, 15)], rand_wait(), rand_wait());

        @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run still active at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

endmodule
